icache_ctrl_arbiter: RTL and testbench
======================================

// Module: icache_ctrl_arbiter
// PURPOSE
//  Shares the icache bank control channel (bypass / flush / selective flush) between NB_MASTERS
//  requesters: cluster ctrl peripheral, debug unit, DMA/loader. Round-robin grants one command at a
//  time, drives the level/4-phase request lines to all NB_BANKS banks, and collects per-bank acks.
//  Returns a per-requester done pulse with an error flag on timeout.
//  Sits between the icache ctrl register units and the icache bank array.
// PARAMETERS
//  NB_MASTERS     3    number of command requesters (>=1)
//  NB_BANKS       4    number of icache banks acking each command (>=1)
//  TIMEOUT_CYCLES 1024 max cycles waiting in one ack phase; 0 disables timeout
//  BYPASS_RST     1    reset value of bypass_req_o (1 = cache bypassed out of reset)
// PORTS
//  clk_i            in  1              clock
//  rst_ni           in  1              async reset, active low
//  cmd_req_i        in  NB_MASTERS     per-master command request, held until gnt
//  cmd_op_i         in  2*NB_MASTERS   per-master op; 00 ENABLE, 01 DISABLE, 10 FLUSH, 11 SEL_FLUSH
//  cmd_addr_i       in  32*NB_MASTERS  per-master selective-flush address
//  cmd_gnt_o        out NB_MASTERS     one-hot grant, op/addr sampled here
//  cmd_done_o       out NB_MASTERS     one-cycle completion pulse to granted master
//  cmd_err_o        out 1              valid with cmd_done_o; 1 = timed out
//  busy_o           out 1              1 whenever state != IDLE
//  bypass_req_o     out 1              level: 1 = banks bypass
//  bypass_ack_i     in  NB_BANKS       per-bank bypass state
//  flush_req_o      out 1              4-phase flush request
//  flush_ack_i      in  NB_BANKS       per-bank flush ack
//  sel_flush_req_o  out 1              4-phase selective-flush request
//  sel_flush_addr_o out 32             selective-flush address, stable while sel_flush_req_o=1
//  sel_flush_ack_i  in  NB_BANKS       per-bank selective-flush ack
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, bypass_req_o=BYPASS_RST, flush/sel_flush req 0,
//   sel_flush_addr_o 0, cmd_gnt_o/cmd_done_o/cmd_err_o/busy_o 0, timer 0.
//  Arbitration: IDLE only. Round-robin starting at the pointer.
//   - cmd_gnt_o is combinational, one-hot, and asserted for one cycle to the winner.
//   - The pointer moves to winner+1 (mod NB_MASTERS) on grant.
//   - cmd_gnt_o is 0 in every other state.
//  Grant cycle T: latch op, addr, master id; next state WAIT_SET; timer cleared.
//   - ENABLE: bypass_req_o<=0. DISABLE: bypass_req_o<=1.
//   - FLUSH: flush_req_o<=1. SEL_FLUSH: sel_flush_req_o<=1, sel_flush_addr_o<=addr.
//   - Request outputs are registered and visible from T+1.
//  WAIT_SET: timer increments each cycle. Exit condition per op:
//   - ENABLE: ~|bypass_ack_i, then DONE.
//   - DISABLE: &bypass_ack_i, then DONE.
//   - FLUSH / SEL_FLUSH: &<op>_ack_i. On exit, drop the req, clear the timer, go to WAIT_CLR.
//  WAIT_CLR (flush ops): wait ~|<op>_ack_i, then DONE. Timer runs.
//  Timeout: timer==TIMEOUT_CYCLES-1 in WAIT_SET or WAIT_CLR with condition unmet.
//   - Drop any flush req, set err, go to DONE.
//   - bypass_req_o keeps the commanded value.
//   - Condition met on the same cycle: success wins.
//  DONE: cmd_done_o[id]=1 and cmd_err_o=err for one cycle; err cleared; next IDLE.
//   - No grant issued in DONE; earliest next grant is the following cycle.
//  Minimum latency with combinational acks:
//   - bypass: gnt T, done T+2.
//   - flush: gnt T, done T+3.
//  Bypass already in commanded state: WAIT_SET exits on its first cycle (done T+2).
//  Banks acking in different cycles: only the AND (set) / NOR (clear) of all banks counts.
//  Never more than one of flush_req_o / sel_flush_req_o high; no new command while busy_o=1.
//  A cmd_req_i drop before grant is legal and that master is skipped.
//  Reset mid-operation returns everything to reset values. The in-flight master gets no done.
//  Unused op/addr of non-granted masters are ignored.
// TESTING
//  1. Reset, no reqs -> bypass_req_o=1, all other outputs 0, busy_o=0.
//  2. M0 ENABLE, banks clear ack 3 cycles after bypass_req_o falls -> gnt[0] at T, done[0] at T+5, err=0.
//  3. M1 FLUSH, acks 1 per bank on successive cycles -> flush_req_o high until 4th ack; done after acks all low.
//  4. M0, M1, M2 req same cycle, each SEL_FLUSH addr 0x1C00_0040+i -> grants in order 0,1,2; each addr held while req high.
//  5. TIMEOUT_CYCLES=8, FLUSH, bank2 never acks -> flush_req_o drops after 8 WAIT_SET cycles; done with err=1.
//  6. rst_ni low during WAIT_CLR of a SEL_FLUSH -> outputs at reset values; no done; next req granted from M0.

Source files
------------

// File: rtl/icache_ctrl_arbiter_if.sv
// Command and bank-control bundle of the icache control arbiter.
// Signal suffixes are given from the arbiter's point of view.
interface icache_ctrl_arbiter_if #(
  parameter int NB_MASTERS = 3,
  parameter int NB_BANKS   = 4
);
  logic [NB_MASTERS-1:0]    cmd_req_i;
  logic [2*NB_MASTERS-1:0]  cmd_op_i;
  logic [32*NB_MASTERS-1:0] cmd_addr_i;
  logic [NB_MASTERS-1:0]    cmd_gnt_o;
  logic [NB_MASTERS-1:0]    cmd_done_o;
  logic                     cmd_err_o;
  logic                     busy_o;
  logic                     bypass_req_o;
  logic [NB_BANKS-1:0]      bypass_ack_i;
  logic                     flush_req_o;
  logic [NB_BANKS-1:0]      flush_ack_i;
  logic                     sel_flush_req_o;
  logic [31:0]              sel_flush_addr_o;
  logic [NB_BANKS-1:0]      sel_flush_ack_i;

  modport slave (
    input  cmd_req_i, cmd_op_i, cmd_addr_i,
    output cmd_gnt_o, cmd_done_o, cmd_err_o, busy_o,
    output bypass_req_o, flush_req_o, sel_flush_req_o, sel_flush_addr_o,
    input  bypass_ack_i, flush_ack_i, sel_flush_ack_i
  );

  modport master (
    output cmd_req_i, cmd_op_i, cmd_addr_i,
    input  cmd_gnt_o, cmd_done_o, cmd_err_o, busy_o,
    input  bypass_req_o, flush_req_o, sel_flush_req_o, sel_flush_addr_o,
    output bypass_ack_i, flush_ack_i, sel_flush_ack_i
  );
endinterface

// File: rtl/icache_ctrl_arbiter.sv
// Round-robin arbiter sharing the icache bank control channel (bypass / flush /
// selective flush) between several requesters, with per-phase ack timeout.
module icache_ctrl_arbiter #(
  parameter int NB_MASTERS     = 3,
  parameter int NB_BANKS       = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit BYPASS_RST     = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  icache_ctrl_arbiter_if.slave bus
);
  localparam int ID_W  = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam bit TMR_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SET, ST_WAIT_CLR, ST_DONE} state_e;
  typedef enum logic [1:0] {OP_ENABLE = 2'b00, OP_DISABLE, OP_FLUSH, OP_SEL_FLUSH} op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              err_q, err_d;
  logic              bypass_q, bypass_d;
  logic              flush_q, flush_d;
  logic              sel_q, sel_d;
  logic [31:0]       addr_q, addr_d;

  logic [NB_BANKS-1:0]   byp_ack, fl_ack, sf_ack;
  logic                  gnt_valid;
  logic [ID_W-1:0]       gnt_idx;
  logic [NB_MASTERS-1:0] gnt_vec, done_vec;
  logic                  set_met, clr_met, timeout;

  assign byp_ack = bus.bypass_ack_i;
  assign fl_ack  = bus.flush_ack_i;
  assign sf_ack  = bus.sel_flush_ack_i;

  // First requester at or after the round-robin pointer wins.
  always_comb begin
    int cand;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NB_MASTERS; k++) begin
      cand = (int'(rr_q) + k) % NB_MASTERS;
      if (!gnt_valid && bus.cmd_req_i[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = ID_W'(cand);
      end
    end
  end

  always_comb begin
    gnt_vec  = '0;
    done_vec = '0;
    if (state_q == ST_IDLE && gnt_valid) gnt_vec[gnt_idx] = 1'b1;
    if (state_q == ST_DONE) done_vec[id_q] = 1'b1;
  end

  always_comb begin
    set_met = 1'b0;
    clr_met = 1'b0;
    case (op_q)
      OP_ENABLE:    set_met = ~|byp_ack;
      OP_DISABLE:   set_met = &byp_ack;
      OP_FLUSH: begin
        set_met = &fl_ack;
        clr_met = ~|fl_ack;
      end
      OP_SEL_FLUSH: begin
        set_met = &sf_ack;
        clr_met = ~|sf_ack;
      end
      default: ;
    endcase
  end

  assign timeout = TMR_EN && (timer_q == TMR_LAST);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rr_d     = rr_q;
    id_d     = id_q;
    timer_d  = timer_q;
    err_d    = err_q;
    bypass_d = bypass_q;
    flush_d  = flush_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d = ST_WAIT_SET;
          rr_d    = (int'(gnt_idx) == NB_MASTERS - 1) ? '0 : gnt_idx + 1'b1;
          id_d    = gnt_idx;
          op_d    = op_e'(bus.cmd_op_i[2*gnt_idx +: 2]);
          timer_d = '0;
          case (op_e'(bus.cmd_op_i[2*gnt_idx +: 2]))
            OP_ENABLE:  bypass_d = 1'b0;
            OP_DISABLE: bypass_d = 1'b1;
            OP_FLUSH:   flush_d  = 1'b1;
            default: begin
              sel_d  = 1'b1;
              addr_d = bus.cmd_addr_i[32*gnt_idx +: 32];
            end
          endcase
        end
      end
      ST_WAIT_SET: begin
        timer_d = timer_q + 1'b1;
        if (set_met) begin
          if (op_q == OP_ENABLE || op_q == OP_DISABLE) begin
            state_d = ST_DONE;
          end else begin
            flush_d = 1'b0;
            sel_d   = 1'b0;
            timer_d = '0;
            state_d = ST_WAIT_CLR;
          end
        end else if (timeout) begin
          // bypass keeps the commanded level; only 4-phase requests are withdrawn
          flush_d = 1'b0;
          sel_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WAIT_CLR: begin
        timer_d = timer_q + 1'b1;
        if (clr_met) begin
          state_d = ST_DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ENABLE;
      rr_q     <= '0;
      id_q     <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
      bypass_q <= BYPASS_RST;
      flush_q  <= 1'b0;
      sel_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      bypass_q <= bypass_d;
      flush_q  <= flush_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
    end
  end

  assign bus.cmd_gnt_o        = gnt_vec;
  assign bus.cmd_done_o       = done_vec;
  assign bus.cmd_err_o        = (state_q == ST_DONE) && err_q;
  assign bus.busy_o           = (state_q != ST_IDLE);
  assign bus.bypass_req_o     = bypass_q;
  assign bus.flush_req_o      = flush_q;
  assign bus.sel_flush_req_o  = sel_q;
  assign bus.sel_flush_addr_o = addr_q;
endmodule

// File: tb/tb_icache_ctrl_arbiter.sv
// Bench for icache_ctrl_arbiter: delayed-ack bank model, vector table, directed
// corner sequences and randomized commands against a transaction-level model.
module tb_icache_ctrl_arbiter;
  localparam int NBM = 3;
  localparam int NBB = 4;
  localparam int TMO = 8;
  localparam logic [1:0] OP_EN = 2'd0, OP_DIS = 2'd1, OP_FL = 2'd2, OP_SF = 2'd3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  icache_ctrl_arbiter_if #(.NB_MASTERS(NBM), .NB_BANKS(NBB)) bus ();

  icache_ctrl_arbiter #(
    .NB_MASTERS(NBM), .NB_BANKS(NBB), .TIMEOUT_CYCLES(TMO), .BYPASS_RST(1'b1)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rr_m = 0;
  bit byp_m = 1'b1;

  int dly[NBB];
  bit stuck[NBB];
  int cnt[3][NBB];
  logic [NBB-1:0] ack_b, ack_f, ack_s;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Each bank follows the request after dly[b] cycles; a stuck bank never raises a flush ack.
  function automatic logic bank_step(input int ch, input int b, input logic req, input logic cur);
    logic nxt;
    nxt = cur;
    if (cur == req) cnt[ch][b] = 0;
    else if (ch != 0 && req && stuck[b]) cnt[ch][b] = 0;
    else if (cnt[ch][b] >= dly[b]) begin
      nxt = req;
      cnt[ch][b] = 0;
    end else cnt[ch][b]++;
    return nxt;
  endfunction

  initial begin
    ack_b = '1;
    ack_f = '0;
    ack_s = '0;
    for (int c = 0; c < 3; c++) for (int b = 0; b < NBB; b++) cnt[c][b] = 0;
    bus.bypass_ack_i = ack_b;
    bus.flush_ack_i = ack_f;
    bus.sel_flush_ack_i = ack_s;
    forever begin
      @(negedge clk);
      for (int b = 0; b < NBB; b++) begin
        ack_b[b] = bank_step(0, b, bus.bypass_req_o, ack_b[b]);
        ack_f[b] = bank_step(1, b, bus.flush_req_o, ack_f[b]);
        ack_s[b] = bank_step(2, b, bus.sel_flush_req_o, ack_s[b]);
      end
      bus.bypass_ack_i = ack_b;
      bus.flush_ack_i = ack_f;
      bus.sel_flush_ack_i = ack_s;
    end
  end

  function automatic int pred_winner(input logic [NBM-1:0] mask);
    for (int k = 0; k < NBM; k++)
      if (mask[(rr_m + k) % NBM]) return (rr_m + k) % NBM;
    return -1;
  endfunction

  // Completion time follows from the slowest bank in each phase, capped by the timeout.
  task automatic pred_timing(input logic [1:0] op, output int off, output bit err, output int reqc);
    int maxd, s;
    bit any_stuck;
    maxd = 0;
    any_stuck = 0;
    for (int b = 0; b < NBB; b++) begin
      if (dly[b] > maxd) maxd = dly[b];
      if (stuck[b]) any_stuck = 1;
    end
    if (op == OP_EN || op == OP_DIS) begin
      s = (byp_m == (op == OP_DIS)) ? 0 : maxd;
      reqc = 0;
      if (s <= TMO - 1) begin off = 2 + s; err = 0; end
      else begin off = TMO + 1; err = 1; end
    end else begin
      s = any_stuck ? 1000 : maxd;
      if (s <= TMO - 1) begin off = 3 + 2 * maxd; err = 0; reqc = s + 1; end
      else begin off = TMO + 1; err = 1; reqc = TMO; end
    end
  endtask

  task automatic wait_gnt(input string tag, output int t, output bit ok);
    ok = 0;
    t = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (|bus.cmd_gnt_o) begin
        ok = 1;
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk({tag, " gnt_timeout"}, 0, 1);
  endtask

  task automatic run_cmd(input string tag, input logic [NBM-1:0] mask, input logic [2*NBM-1:0] ops,
                         input logic [32*NBM-1:0] addrs, input int exp_win, input int exp_off,
                         input bit exp_err, input int exp_reqc);
    int t, off, reqc;
    bit ok, seen, extra, gnt_busy, byp_new;
    logic [1:0] op;
    logic [31:0] addr;
    op = ops[2*exp_win +: 2];
    addr = addrs[32*exp_win +: 32];
    bus.cmd_op_i = ops;
    bus.cmd_addr_i = addrs;
    bus.cmd_req_i = mask;
    wait_gnt(tag, t, ok);
    if (!ok) begin
      bus.cmd_req_i = '0;
      return;
    end
    chk({tag, " gnt"}, bus.cmd_gnt_o, 64'(1) << exp_win);
    @(posedge clk);
    #1;
    bus.cmd_req_i = '0;
    byp_new = (op == OP_EN) ? 1'b0 : (op == OP_DIS) ? 1'b1 : byp_m;
    seen = 0; off = 0; reqc = 0; gnt_busy = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.flush_req_o || bus.sel_flush_req_o) reqc++;
      chk({tag, " req_excl"}, bus.flush_req_o & bus.sel_flush_req_o, 0);
      if (bus.sel_flush_req_o) chk({tag, " sel_addr"}, bus.sel_flush_addr_o, addr);
      if (bus.cmd_gnt_o != '0) gnt_busy = 1;
      if (cyc - t == 1) begin
        chk({tag, " busy"}, bus.busy_o, 1);
        chk({tag, " flush_req_t1"}, bus.flush_req_o, op == OP_FL);
        chk({tag, " sel_req_t1"}, bus.sel_flush_req_o, op == OP_SF);
        chk({tag, " bypass_req_t1"}, bus.bypass_req_o, byp_new);
      end
      if (|bus.cmd_done_o) begin
        seen = 1;
        off = cyc - t;
        chk({tag, " done_vec"}, bus.cmd_done_o, 64'(1) << exp_win);
        chk({tag, " err"}, bus.cmd_err_o, exp_err);
        chk({tag, " bypass_lvl"}, bus.bypass_req_o, byp_new);
      end
    end
    chk({tag, " done_seen"}, seen, 1);
    if (seen) begin
      chk({tag, " done_latency"}, off, exp_off);
      chk({tag, " req_cycles"}, reqc, exp_reqc);
    end
    chk({tag, " gnt_while_busy"}, gnt_busy, 0);
    rr_m = (exp_win + 1) % NBM;
    byp_m = byp_new;
    extra = 0;
    repeat (14) begin
      @(negedge clk);
      if (|bus.cmd_done_o) extra = 1;
    end
    chk({tag, " done_extra"}, extra, 0);
    chk({tag, " idle"}, bus.busy_o, 0);
    $display("txn %s: master=%0d op=%0d latency=%0d err=%0b", tag, exp_win, op, off, bus.cmd_err_o);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " bypass_req"}, bus.bypass_req_o, 1);
    chk({tag, " flush_req"}, bus.flush_req_o, 0);
    chk({tag, " sel_req"}, bus.sel_flush_req_o, 0);
    chk({tag, " sel_addr"}, bus.sel_flush_addr_o, 0);
    chk({tag, " gnt"}, bus.cmd_gnt_o, 0);
    chk({tag, " done"}, bus.cmd_done_o, 0);
    chk({tag, " err"}, bus.cmd_err_o, 0);
    chk({tag, " busy"}, bus.busy_o, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rr_m = 0;
    byp_m = 1'b1;
    repeat (14) @(negedge clk);
  endtask

  typedef struct {
    logic [NBM-1:0] mask;
    logic [1:0]     op;
    logic [15:0]    dly;
    logic [3:0]     stuck;
    int             win;
    int             off;
    bit             err;
    int             reqc;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, win, off, reqc, r, bsel;
    bit ok, err, seen;
    logic [NBM-1:0] mask;
    logic [2*NBM-1:0] ops;
    logic [32*NBM-1:0] addrs;

    tbl[0]  = '{3'b001, OP_EN,  16'h3333, 4'b0000, 0, 5,  1'b0, 0};
    tbl[1]  = '{3'b001, OP_EN,  16'h0000, 4'b0000, 0, 2,  1'b0, 0};
    tbl[2]  = '{3'b111, OP_FL,  16'h0000, 4'b0000, 1, 3,  1'b0, 1};
    tbl[3]  = '{3'b011, OP_DIS, 16'h7777, 4'b0000, 0, 9,  1'b0, 0};
    tbl[4]  = '{3'b100, OP_EN,  16'h0008, 4'b0000, 2, 9,  1'b1, 0};
    tbl[5]  = '{3'b010, OP_FL,  16'h0000, 4'b0100, 1, 9,  1'b1, 8};
    tbl[6]  = '{3'b101, OP_SF,  16'h1111, 4'b0000, 2, 5,  1'b0, 2};
    tbl[7]  = '{3'b110, OP_DIS, 16'h2222, 4'b0000, 1, 4,  1'b0, 0};
    tbl[8]  = '{3'b011, OP_SF,  16'h2130, 4'b0000, 0, 9,  1'b0, 4};
    tbl[9]  = '{3'b100, OP_FL,  16'h0700, 4'b0000, 2, 17, 1'b0, 8};
    tbl[10] = '{3'b001, OP_DIS, 16'h0000, 4'b0000, 0, 2,  1'b0, 0};

    for (int b = 0; b < NBB; b++) begin dly[b] = 0; stuck[b] = 0; end
    rst_n = 1'b0;
    bus.cmd_req_i = '0;
    bus.cmd_op_i = '0;
    bus.cmd_addr_i = '0;

    // reset values, both while held and after release
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("rst_hold");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("rst_idle");

    for (int i = 0; i < 11; i++) begin
      for (int b = 0; b < NBB; b++) begin
        dly[b] = int'(tbl[i].dly[4*b +: 4]);
        stuck[b] = tbl[i].stuck[b];
      end
      ops = 6'($urandom);
      addrs = {$urandom, $urandom, $urandom};
      ops[2*tbl[i].win +: 2] = tbl[i].op;
      run_cmd($sformatf("tbl%0d", i), tbl[i].mask, ops, addrs, tbl[i].win, tbl[i].off,
              tbl[i].err, tbl[i].reqc);
      for (int b = 0; b < NBB; b++) stuck[b] = 0;
    end

    // staggered flush acks: request stays up until the fourth bank acks
    dly[0] = 0; dly[1] = 1; dly[2] = 2; dly[3] = 3;
    ops = {OP_EN, OP_FL, OP_DIS};
    run_cmd("t3_staggered", 3'b010, ops, {$urandom, $urandom, $urandom}, 1, 9, 1'b0, 4);

    for (int it = 0; it < 40; it++) begin
      mask = 3'($urandom_range(1, 7));
      ops = 6'($urandom);
      addrs = {$urandom, $urandom, $urandom};
      for (int b = 0; b < NBB; b++) begin dly[b] = $urandom_range(0, 3); stuck[b] = 0; end
      r = $urandom_range(0, 9);
      bsel = $urandom_range(0, NBB - 1);
      if (r < 2) dly[bsel] = $urandom_range(5, 10);
      else if (r < 4) stuck[bsel] = 1;
      win = pred_winner(mask);
      pred_timing(ops[2*win +: 2], off, err, reqc);
      run_cmd($sformatf("rnd%0d", it), mask, ops, addrs, win, off, err, reqc);
      for (int b = 0; b < NBB; b++) stuck[b] = 0;
    end

    // reset while a selective flush sits in its clear phase
    for (int b = 0; b < NBB; b++) dly[b] = 2;
    bus.cmd_op_i = {OP_EN, OP_SF, OP_EN};
    bus.cmd_addr_i = {32'h0, 32'hABCD_0100, 32'h0};
    bus.cmd_req_i = 3'b010;
    wait_gnt("t6", t, ok);
    @(posedge clk);
    #1;
    bus.cmd_req_i = '0;
    while (cyc - t < 4) @(negedge clk);
    chk("t6 in_clr_busy", bus.busy_o, 1);
    chk("t6 in_clr_req", bus.sel_flush_req_o, 0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_rst");
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (|bus.cmd_done_o) seen = 1;
    end
    rst_n = 1'b1;
    rr_m = 0;
    byp_m = 1'b1;
    repeat (14) begin
      @(negedge clk);
      if (|bus.cmd_done_o) seen = 1;
    end
    chk("t6 no_done", seen, 0);
    $display("txn t6_reset: reset applied in clear phase");
    for (int b = 0; b < NBB; b++) dly[b] = 0;
    run_cmd("t6_after", 3'b101, {OP_DIS, OP_EN, OP_EN}, {$urandom, $urandom, $urandom}, 0, 2, 1'b0, 0);

    // three simultaneous selective flushes, requests held until each grant
    do_reset();
    bus.cmd_op_i = {OP_SF, OP_SF, OP_SF};
    bus.cmd_addr_i = {32'h1C00_0042, 32'h1C00_0041, 32'h1C00_0040};
    bus.cmd_req_i = 3'b111;
    for (int i = 0; i < NBM; i++) begin
      wait_gnt($sformatf("t4_m%0d", i), t, ok);
      if (!ok) break;
      chk($sformatf("t4 gnt_order%0d", i), bus.cmd_gnt_o, 64'(1) << i);
      @(posedge clk);
      #1;
      bus.cmd_req_i[i] = 1'b0;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (bus.sel_flush_req_o)
          chk($sformatf("t4 addr%0d", i), bus.sel_flush_addr_o, 32'h1C00_0040 + i);
        if (|bus.cmd_done_o) begin
          seen = 1;
          chk($sformatf("t4 done%0d", i), bus.cmd_done_o, 64'(1) << i);
          chk($sformatf("t4 err%0d", i), bus.cmd_err_o, 0);
        end
      end
      chk($sformatf("t4 done_seen%0d", i), seen, 1);
      $display("txn t4: master=%0d sel_flush done=%0b", i, seen);
    end
    bus.cmd_req_i = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
